// File: rtl/fetch_sequencer_if.sv
// Fetch front-end bundle: redirect, instruction-memory request/response and decode handoff.
// The master modport is the fetch sequencer; slave is the surrounding pipeline/memory.
interface fetch_sequencer_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               inst_valid;
    logic               inst_ready;
    logic [INSTR_W-1:0] inst_data;
    logic [ADDR_W-1:0]  inst_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: issues sequential imem reads under a credit limit, queues the
// returned words with their PCs for decode, and flushes/drains outstanding reads on redirect.
module fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1),
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW1-1:0] DEPTH_C = CW1'(DEPTH);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]      live_q, live_d, stale_q, stale_d, count_q, count_d;
    logic [CW-1:0]      live_adj_s, stale_adj_s;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               req_valid_q, req_valid_d;
    logic [INSTR_W-1:0] data_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q   [DEPTH];
    logic               req_fire_s, pop_s, push_s, rsp_stale_s, rsp_live_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Responses retire stale reads first since memory answers strictly in request order.
    assign req_fire_s  = req_valid_q & bus.imem_req_ready;
    assign pop_s       = (count_q != '0) & bus.inst_ready;
    assign rsp_stale_s = bus.imem_rsp_valid & (stale_q != '0);
    assign rsp_live_s  = bus.imem_rsp_valid & (stale_q == '0) & (live_q != '0);
    assign push_s      = rsp_live_s & ~bus.redirect_valid;

    // Bookkeeping for addresses, credits and queue pointers; redirect overrides after folding in this cycle's accept/response.
    always_comb begin
        live_adj_s  = live_q + CW'(req_fire_s) - CW'(rsp_live_s);
        stale_adj_s = stale_q - CW'(rsp_stale_s);
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            rsp_pc_d   = bus.redirect_pc;
            live_d     = '0;
            stale_d    = stale_adj_s + live_adj_s;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            fetch_pc_d = req_fire_s ? (fetch_pc_q + PC_STEP) : fetch_pc_q;
            rsp_pc_d   = push_s ? (rsp_pc_q + PC_STEP) : rsp_pc_q;
            live_d     = live_adj_s;
            stale_d    = stale_adj_s;
            count_d    = count_q + CW'(push_s) - CW'(pop_s);
            wr_ptr_d   = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            rd_ptr_d   = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: stay in DRAIN while discarded reads are still owed by memory.
    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) begin
            state_d = (stale_d != '0) ? ST_DRAIN : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:   state_d = ST_RUN;
                ST_DRAIN: state_d = (stale_d == '0) ? ST_RUN : ST_DRAIN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // FSM output: request only when every outstanding read is guaranteed a queue slot.
    always_comb begin
        req_valid_d = 1'b0;
        case (state_d)
            ST_RUN:   req_valid_d = (CW1'(count_d) + CW1'(live_d)) < DEPTH_C;
            ST_DRAIN: req_valid_d = 1'b0;
            default:  req_valid_d = 1'b0;
        endcase
    end

    // Datapath registers and instruction queue storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            live_q      <= '0;
            stale_q     <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            req_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            live_q      <= live_d;
            stale_q     <= stale_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            req_valid_q <= req_valid_d;
            if (push_s) begin
                data_mem_q[wr_ptr_q] <= bus.imem_rsp_data;
                pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
            end
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.inst_valid     = (count_q != '0);
    assign bus.inst_data      = data_mem_q[rd_ptr_q];
    assign bus.inst_pc        = pc_mem_q[rd_ptr_q];
endmodule
